// File: rtl/fetch_if_id_pkg.sv
// Shared definitions for the instruction-fetch stage and its pipeline registers.
package fetch_if_id_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_HOLD  = 2'd2,
    ST_DRAIN = 2'd3
  } fetch_state_e;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
  localparam int          OPC_MSB          = 31;
  localparam int          OPC_LSB          = 26;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  // Sequential fetch address; wraps modulo 2^32.
  function automatic logic [31:0] pc_inc(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/if_id_reg.sv
// Pipeline register holding an instruction and its PC+4.
// Priority is flush > stall > load; an empty cycle only clears the valid bit.
module if_id_reg
  import fetch_if_id_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush_i,
  input  logic        stall_i,
  input  logic        load_i,
  input  logic [31:0] instr_i,
  input  logic [31:0] pc4_i,
  output logic [31:0] instr_o,
  output logic [31:0] pc4_o,
  output logic        valid_o
);

  logic [31:0] instr_q;
  logic [31:0] pc4_q;
  logic        valid_q;

  // Register update: a flush turns the slot into a NOP but keeps its PC+4.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_q <= NOP_INSTR;
      pc4_q   <= 32'h0;
      valid_q <= 1'b0;
    end else if (flush_i) begin
      instr_q <= NOP_INSTR;
      valid_q <= 1'b0;
    end else if (!stall_i) begin
      if (load_i) begin
        instr_q <= instr_i;
        pc4_q   <= pc4_i;
        valid_q <= 1'b1;
      end else begin
        valid_q <= 1'b0;
      end
    end
  end

  assign instr_o = instr_q;
  assign pc4_o   = pc4_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/fetch_if_id.sv
// Instruction fetch with a request/ready memory handshake, a one-entry skid
// buffer for instructions returned while decode is stalled, and the IF/ID register.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | one cycle after reset, no request
// ST_FETCH | request on PC, accept data or redirect
// ST_HOLD  | skid holds one instruction, decode stalled, no request
// ST_DRAIN | redirect pending behind an outstanding request on old PC
module fetch_if_id
  import fetch_if_id_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        Stall,
  input  logic        Flush,
  input  logic        PCSrc,
  input  logic [31:0] PCTarget,
  output logic        IMemReq,
  output logic [31:0] IMemAddr,
  input  logic        IMemReady,
  input  logic [31:0] IMemData,
  output logic [31:0] Instr_ID,
  output logic [31:0] PCPlus4_ID,
  output logic        Valid_ID,
  output logic [5:0]  OpCode_ID
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  tgt_q, tgt_d;
  logic [31:0]  skid_instr_q, skid_instr_d;
  logic [31:0]  skid_pc4_q, skid_pc4_d;
  logic [31:0]  pc_plus4;
  logic         load;
  logic [31:0]  ld_instr;
  logic [31:0]  ld_pc4;

  assign pc_plus4 = pc_inc(pc_q);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state: redirect wins over stall; a redirect without data must drain first.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  state_d = ST_FETCH;
      ST_FETCH: begin
        if (PCSrc) begin
          if (!IMemReady) state_d = ST_DRAIN;
        end else if (IMemReady && Stall) begin
          state_d = ST_HOLD;
        end
      end
      ST_HOLD:  if (PCSrc || !Stall) state_d = ST_FETCH;
      ST_DRAIN: if (IMemReady) state_d = ST_FETCH;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Outputs: memory request and the IF/ID load source (memory or skid).
  always_comb begin
    IMemReq  = (state_q == ST_FETCH) || (state_q == ST_DRAIN);
    load     = 1'b0;
    ld_instr = IMemData;
    ld_pc4   = pc_plus4;
    case (state_q)
      ST_FETCH: load = IMemReady && !PCSrc && !Stall;
      ST_HOLD: begin
        load     = !PCSrc && !Stall;
        ld_instr = skid_instr_q;
        ld_pc4   = skid_pc4_q;
      end
      default: load = 1'b0;
    endcase
  end

  // Datapath next values: PC, pending redirect target and skid capture.
  always_comb begin
    pc_d         = pc_q;
    tgt_d        = tgt_q;
    skid_instr_d = skid_instr_q;
    skid_pc4_d   = skid_pc4_q;
    case (state_q)
      ST_FETCH: begin
        if (PCSrc) begin
          if (IMemReady) pc_d  = PCTarget;
          else           tgt_d = PCTarget;
        end else if (IMemReady) begin
          pc_d = pc_plus4;
          if (Stall) begin
            skid_instr_d = IMemData;
            skid_pc4_d   = pc_plus4;
          end
        end
      end
      ST_HOLD: if (PCSrc) pc_d = PCTarget;
      ST_DRAIN: begin
        if (PCSrc)     tgt_d = PCTarget;
        if (IMemReady) pc_d  = PCSrc ? PCTarget : tgt_q;
      end
      default: pc_d = pc_q;
    endcase
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q         <= RESET_PC;
      tgt_q        <= 32'h0;
      skid_instr_q <= 32'h0;
      skid_pc4_q   <= 32'h0;
    end else begin
      pc_q         <= pc_d;
      tgt_q        <= tgt_d;
      skid_instr_q <= skid_instr_d;
      skid_pc4_q   <= skid_pc4_d;
    end
  end

  assign IMemAddr = pc_q;

  if_id_reg u_if_id (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush_i (Flush),
    .stall_i (Stall),
    .load_i  (load),
    .instr_i (ld_instr),
    .pc4_i   (ld_pc4),
    .instr_o (Instr_ID),
    .pc4_o   (PCPlus4_ID),
    .valid_o (Valid_ID)
  );

  assign OpCode_ID = Instr_ID[OPC_MSB:OPC_LSB];

endmodule

// File: tb/tb_fetch_if_id.sv
// Bench for fetch_if_id: directed scenarios then random traffic, all checked
// against a transaction-level model of the fetch stage.
module tb_fetch_if_id;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        Stall, Flush, PCSrc, IMemReady;
  logic [31:0] PCTarget, IMemData, w_data;
  logic        IMemReq, Valid_ID;
  logic [31:0] IMemAddr, Instr_ID, PCPlus4_ID;
  logic [5:0]  OpCode_ID;
  logic        w_req, w_valid;
  logic [31:0] w_addr, w_instr, w_pc4;
  logic [5:0]  w_opc;

  always #5 clk = ~clk;

  fetch_if_id dut (
    .clk(clk), .rst_n(rst_n), .Stall(Stall), .Flush(Flush), .PCSrc(PCSrc),
    .PCTarget(PCTarget), .IMemReq(IMemReq), .IMemAddr(IMemAddr),
    .IMemReady(IMemReady), .IMemData(IMemData), .Instr_ID(Instr_ID),
    .PCPlus4_ID(PCPlus4_ID), .Valid_ID(Valid_ID), .OpCode_ID(OpCode_ID)
  );

  fetch_if_id #(.RESET_PC(32'hFFFF_FFFC)) dut_w (
    .clk(clk), .rst_n(rst_n), .Stall(Stall), .Flush(Flush), .PCSrc(PCSrc),
    .PCTarget(PCTarget), .IMemReq(w_req), .IMemAddr(w_addr),
    .IMemReady(IMemReady), .IMemData(w_data), .Instr_ID(w_instr),
    .PCPlus4_ID(w_pc4), .Valid_ID(w_valid), .OpCode_ID(w_opc)
  );

  int n_chk = 0;
  int n_err = 0;
  bit mem_ident;

  // Reference model: fetch pointer, outstanding redirect, held instruction, IF/ID slot.
  bit          m_started, m_holding, m_draining;
  logic [31:0] m_pc, m_tgt, m_held_instr, m_held_pc4;
  logic [31:0] m_instr, m_pc4;
  bit          m_valid;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (mem_ident) return a;
    return a * 32'h9E37_79B1 + 32'h1234_5677;
  endfunction

  function automatic void model_reset();
    m_started = 0; m_holding = 0; m_draining = 0;
    m_pc = 32'h0; m_tgt = 32'h0; m_held_instr = 32'h0; m_held_pc4 = 32'h0;
    m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 0;
  endfunction

  function automatic void model_step(input bit s, input bit f, input bit p,
                                     input logic [31:0] t, input bit r);
    bit          deliver = 0;
    logic [31:0] d_instr = 32'h0;
    logic [31:0] d_pc4   = 32'h0;
    if (!m_started) begin
      m_started = 1;
    end else if (m_holding) begin
      if (p) begin
        m_pc = t; m_holding = 0;
      end else if (!s) begin
        deliver = 1; d_instr = m_held_instr; d_pc4 = m_held_pc4; m_holding = 0;
      end
    end else if (m_draining) begin
      if (p) m_tgt = t;
      if (r) begin m_pc = m_tgt; m_draining = 0; end
    end else if (p) begin
      if (r) m_pc = t;
      else begin m_tgt = t; m_draining = 1; end
    end else if (r) begin
      if (s) begin
        m_held_instr = mem_word(m_pc); m_held_pc4 = m_pc + 4; m_holding = 1;
      end else begin
        deliver = 1; d_instr = mem_word(m_pc); d_pc4 = m_pc + 4;
      end
      m_pc = m_pc + 4;
    end
    if (f) begin
      m_instr = 32'h0; m_valid = 0;
    end else if (!s) begin
      if (deliver) begin m_instr = d_instr; m_pc4 = d_pc4; m_valid = 1; end
      else m_valid = 0;
    end
  endfunction

  task automatic check_all();
    chk("req",    32'(IMemReq),    32'(m_started && !m_holding));
    chk("addr",   IMemAddr,        m_pc);
    chk("instr",  Instr_ID,        m_instr);
    chk("pc4",    PCPlus4_ID,      m_pc4);
    chk("valid",  32'(Valid_ID),   32'(m_valid));
    chk("opcode", 32'(OpCode_ID),  32'(m_instr[31:26]));
  endtask

  // Called at a negedge: drive inputs, let the DUT clock, update model, compare.
  task automatic cycle(input bit s, input bit f, input bit p,
                       input logic [31:0] t, input bit r);
    Stall = s; Flush = f; PCSrc = p; PCTarget = t; IMemReady = r;
    IMemData = mem_word(IMemAddr);
    w_data   = mem_word(w_addr);
    @(posedge clk);
    model_step(s, f, p, t, r);
    @(negedge clk);
    check_all();
  endtask

  initial begin
    bit s, f, p, r;
    logic [31:0] t;
    rst_n = 0; Stall = 0; Flush = 0; PCSrc = 0; PCTarget = 0;
    IMemReady = 0; IMemData = 0; w_data = 0; mem_ident = 1;
    model_reset();
    repeat (3) @(negedge clk);
    check_all();
    chk("w_addr_reset", w_addr, 32'hFFFF_FFFC);
    chk("w_req_reset",  32'(w_req), 32'h0);
    rst_n = 1;

    // Zero-wait memory, data equals address.
    cycle(0, 0, 0, 32'h0, 1);
    chk("w_addr_first", w_addr, 32'hFFFF_FFFC);
    cycle(0, 0, 0, 32'h0, 1);
    chk("w_addr_wrap", w_addr, 32'h0);
    chk("w_pc4_wrap",  w_pc4,  32'h0);
    chk("first_instr", Instr_ID, 32'h0);
    cycle(0, 0, 0, 32'h0, 1);
    chk("second_instr", Instr_ID, 32'h4);
    cycle(0, 0, 0, 32'h0, 1);
    chk("third_pc4", PCPlus4_ID, 32'hC);

    // Stall three cycles while memory stays ready, then release.
    repeat (3) cycle(1, 0, 0, 32'h0, 1);
    chk("hold_req", 32'(IMemReq), 32'h0);
    repeat (3) cycle(0, 0, 0, 32'h0, 1);

    // Redirect plus flush while memory waits two cycles.
    cycle(0, 1, 1, 32'h40, 0);
    cycle(0, 0, 0, 32'h0, 0);
    cycle(0, 0, 0, 32'h0, 1);
    chk("drain_target", IMemAddr, 32'h40);
    repeat (2) cycle(0, 0, 0, 32'h0, 1);

    // Redirect during a stalled hold drops the skid.
    cycle(1, 0, 0, 32'h0, 1);
    cycle(1, 0, 1, 32'h100, 0);
    chk("hold_redirect", IMemAddr, 32'h100);
    repeat (2) cycle(0, 0, 0, 32'h0, 1);

    // Reset while a request is outstanding, with a late ready.
    repeat (2) cycle(0, 0, 0, 32'h0, 0);
    rst_n = 0; IMemReady = 1;
    #1;
    model_reset();
    check_all();
    @(posedge clk);
    @(negedge clk);
    check_all();
    rst_n = 1;
    cycle(0, 0, 0, 32'h0, 1);
    repeat (3) cycle(0, 0, 0, 32'h0, 1);

    // Random traffic.
    mem_ident = 0;
    for (int i = 0; i < 3000; i++) begin
      s = ($urandom_range(3) == 0);
      p = ($urandom_range(7) == 0);
      f = p ? ($urandom_range(3) != 0) : ($urandom_range(15) == 0);
      r = ($urandom_range(3) != 0);
      case ($urandom_range(3))
        0:       t = 32'hFFFF_FFF8 + 32'($urandom_range(1)) * 4;
        1:       t = $urandom;
        default: t = 32'($urandom_range(1023)) << 2;
      endcase
      cycle(s, f, p, t, r);
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/fetch_if_id.md
# fetch_if_id

Instruction-fetch stage plus IF/ID pipeline register of the MIPS32 core; directly upstream of the control unit, which receives `OpCode_ID`. Owns the program counter, runs a request/ready handshake with instruction memory, and presents one instruction per cycle to decode. Honours stall from the hazard unit, flush and branch/jump redirect from the execute stage.

## Interface
- `RESET_PC`, 32'h0000_0000, PC value loaded on reset
- `clk`  in  1  single clock, all state on rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `Stall`  in  1  decode cannot accept; IF/ID holds
- `Flush`  in  1  squash IF/ID contents (taken branch/jump)
- `PCSrc`  in  1  redirect fetch to `PCTarget`
- `PCTarget`  in  32  redirect address
- `IMemReq`  out  1  fetch request, address valid
- `IMemAddr`  out  32  word address to instruction memory
- `IMemReady`  in  1  `IMemData` valid this cycle, completes request
- `IMemData`  in  32  fetched instruction
- `Instr_ID`  out  32  instruction in IF/ID
- `PCPlus4_ID`  out  32  address of `Instr_ID` + 4
- `Valid_ID`  out  1  IF/ID holds a real instruction
- `OpCode_ID`  out  6  `Instr_ID[31:26]`, to control unit

## Operation
- Registers: `PC`, `TargetPend`, skid `{SkidInstr, SkidPC4}`, IF/ID `{Instr_ID, PCPlus4_ID, Valid_ID}`, state.
- States: IDLE, FETCH, HOLD, DRAIN. `IMemReq` = 1 in FETCH and DRAIN only; `IMemAddr` = `PC`.
- Handshake: while `IMemReq`=1, `IMemAddr` stable until the cycle `IMemReady`=1. `IMemReady` while `IMemReq`=0 is ignored.
- IDLE: next cycle -> FETCH.
- FETCH, `PCSrc`=1, `IMemReady`=1: discard data, `PC`<=`PCTarget`, stay FETCH.
- FETCH, `PCSrc`=1, `IMemReady`=0: `TargetPend`<=`PCTarget`, -> DRAIN.
- FETCH, `IMemReady`=1, `Stall`=0: IF/ID <= {`IMemData`, `PC`+4, 1}; `PC`<=`PC`+4.
- FETCH, `IMemReady`=1, `Stall`=1: skid <= {`IMemData`, `PC`+4}; `PC`<=`PC`+4; -> HOLD.
- HOLD: no request. `Stall`=0: IF/ID <= {skid, 1}, -> FETCH. `PCSrc`=1: drop skid, `PC`<=`PCTarget`, -> FETCH (priority over stall release).
- DRAIN: keep request on old `PC`; `PCSrc`=1 overwrites `TargetPend`; on `IMemReady`: discard data, `PC`<=`TargetPend` (or `PCTarget` if `PCSrc` same cycle), -> FETCH.
- IF/ID priority: `Flush` > `Stall` > load. Flush: `Instr_ID`<=32'h0 (NOP), `Valid_ID`<=0, `PCPlus4_ID` unchanged. Stall: hold all. No load when no data: `Valid_ID`<=0.
- PC arithmetic modulo 2^32; `PC`+4 from 32'hFFFF_FFFC wraps to 0. Bits [1:0] of `PCTarget` passed unchanged (no alignment check).

## Timing
- Reset (async assert): `PC`=`RESET_PC`, state IDLE, `IMemReq`=0, `Instr_ID`=0, `PCPlus4_ID`=0, `Valid_ID`=0, `OpCode_ID`=0, skid=0, `TargetPend`=0.
- First `IMemReq`=1 in second rising edge after `rst_n` deasserts (IDLE then FETCH).
- Latency: instruction on `Instr_ID` one cycle after its `IMemReady` (unstalled). Zero-wait memory (`IMemReady` tied 1) gives one instruction per cycle.
- Redirect penalty: `IMemAddr`=`PCTarget` the cycle after `PCSrc` (FETCH with ready or HOLD); after drain completes otherwise.
- Reset mid-request: request dropped immediately, late `IMemReady` ignored in IDLE.

## Structure
- Shared package: state encoding, `NOP_INSTR` = 32'h0, opcode field bounds [31:26], default `RESET_PC`.
- One sub-module: `if_id_reg` — IF/ID register with Flush/Stall/load priority, reused for later pipeline registers.

## Test plan
- Reset, `IMemReady`=1 constant, data = address -> `IMemAddr` 0,4,8; `Instr_ID` 0,4,8 one cycle later, `PCPlus4_ID` 4,8,12.
- `Stall` 3 cycles while ready -> one skid capture, `IMemReq`=0 in HOLD, `Instr_ID` frozen; after release no instruction lost or duplicated.
- `PCSrc`+`Flush` with `PCTarget`=32'h40 while memory waits 2 cycles -> DRAIN, old data discarded, `Valid_ID`=0, next address 32'h40.
- `PCSrc` during HOLD with `Stall`=1 -> skid dropped, next `IMemAddr`=`PCTarget`.
- `RESET_PC`=32'hFFFF_FFFC -> second address 32'h0000_0000.
- `rst_n` low mid-request with late `IMemReady` -> all outputs reset values, no IF/ID load.
